// File: rtl/banked_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banked_ram_pkg
// Description : Shared widths, decode helpers and the response-stage record
//               used by the banked data RAM and its bank macro wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package banked_ram_pkg;

    localparam int WORD_W     = 32;
    localparam int BE_W       = 4;
    localparam int ADDR_W     = 32;
    // Bank index field in the response record is sized for the largest
    // supported bank count (8) so one record type serves every configuration.
    localparam int BANK_IDX_W = 3;

    // Number of address bits that select a bank; a single bank needs none.
    function automatic int bank_bits(input int n_banks);
        return (n_banks > 1) ? $clog2(n_banks) : 0;
    endfunction

    // Width of a round-robin pointer; kept at least one bit wide.
    function automatic int ptr_bits(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

    // First response stage, captured in the grant cycle.
    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic                  we;
        logic [BANK_IDX_W-1:0] bank;
    } resp_stage_t;

endpackage : banked_ram_pkg
`default_nettype wire

// File: rtl/ram_bank.sv
`default_nettype none
// ============================================================================
// Module      : ram_bank
// Description : Single-port byte-writable SRAM, BANK_WORDS x 32, with a
//               registered read port. Replaceable by a hard-macro wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bank
    import banked_ram_pkg::*;
#(
    parameter int BANK_WORDS = 4096,
    parameter int AW         = $clog2(BANK_WORDS)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [BANK_WORDS];
    logic [WORD_W-1:0] r_rdata;

    // Byte-masked write, or capture of the addressed word on a read.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule : ram_bank
`default_nettype wire

// File: rtl/banked_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : banked_data_ram
// Description : Multi-port, multi-bank data memory. Each bank has its own
//               round-robin arbiter; ports hitting different banks proceed in
//               parallel. Out-of-range accesses complete with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_data_ram
    import banked_ram_pkg::*;
#(
    parameter int N_PORTS    = 2,
    parameter int N_BANKS    = 4,
    parameter int BANK_WORDS = 4096,
    parameter int OUT_REG    = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_PORTS-1:0]        req_i,
    output logic [N_PORTS-1:0]        gnt_o,
    input  logic [N_PORTS*ADDR_W-1:0] addr_i,
    input  logic [N_PORTS-1:0]        we_i,
    input  logic [N_PORTS*BE_W-1:0]   be_i,
    input  logic [N_PORTS*WORD_W-1:0] wdata_i,
    output logic [N_PORTS-1:0]        rvalid_o,
    output logic [N_PORTS*WORD_W-1:0] rdata_o,
    output logic [N_PORTS-1:0]        err_o
);

    localparam int OFFW = $clog2(BANK_WORDS);
    localparam int BW   = bank_bits(N_BANKS);
    localparam int HI   = 2 + OFFW + BW;
    localparam int PW   = ptr_bits(N_PORTS);

    logic [OFFW-1:0]           w_off   [N_PORTS];
    logic [BANK_IDX_W-1:0]     w_bank  [N_PORTS];
    logic [N_PORTS-1:0]        w_oor;
    logic [N_BANKS*N_PORTS-1:0] w_bgnt_all;
    logic [WORD_W-1:0]         w_bank_rdata [N_BANKS];
    logic [N_PORTS-1:0]        w_gnt;
    resp_stage_t               r_s1    [N_PORTS];
    logic [N_PORTS-1:0]        w_rv;
    logic [N_PORTS-1:0]        w_re;
    logic [N_PORTS*WORD_W-1:0] w_rd_flat;

    // ------------------------------------------------------------------
    // Per-port address decode: offset, bank and out-of-range detection.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] w_addr;
        logic [ADDR_W-1:0] w_bank_full;
        logic              w_unused;

        assign w_addr      = addr_i[ADDR_W*p +: ADDR_W];
        assign w_bank_full = (w_addr >> (2 + OFFW)) & ADDR_W'(N_BANKS - 1);
        assign w_off[p]    = w_addr[2 +: OFFW];
        assign w_bank[p]   = w_bank_full[BANK_IDX_W-1:0];
        assign w_oor[p]    = (w_addr >> HI) != '0;
        // Byte-lane bits and spare bank bits carry no meaning here.
        assign w_unused    = ^{w_addr[1:0], w_bank_full[ADDR_W-1:BANK_IDX_W]};
    end

    // ------------------------------------------------------------------
    // Per-bank round-robin arbiter and SRAM.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [PW-1:0]      r_ptr;
        logic [N_PORTS-1:0] w_cand;
        logic               w_hit;
        logic [PW-1:0]      w_win;
        logic [OFFW-1:0]    w_sel_off;
        logic               w_sel_we;
        logic [BE_W-1:0]    w_sel_be;
        logic [WORD_W-1:0]  w_sel_wdata;
        logic [WORD_W-1:0]  w_rdata;

        // Candidates: in-range requesters aimed at this bank, none in reset.
        always_comb begin
            w_cand = '0;
            for (int p = 0; p < N_PORTS; p++) begin
                w_cand[p] = req_i[p] & ~w_oor[p] & ~rst_i &
                            (w_bank[p] == BANK_IDX_W'(b));
            end
        end

        // First candidate at or after the pointer, wrapping over the ports.
        always_comb begin
            int w_idx;
            w_hit = 1'b0;
            w_win = '0;
            w_idx = 0;
            for (int k = 0; k < N_PORTS; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N_PORTS) begin
                    w_idx = w_idx - N_PORTS;
                end
                if (!w_hit && w_cand[w_idx]) begin
                    w_hit = 1'b1;
                    w_win = PW'(w_idx);
                end
            end
        end

        // Pointer moves just past the winner; idle banks keep their pointer.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_ptr <= '0;
            end else if (w_hit) begin
                r_ptr <= (w_win == PW'(N_PORTS - 1)) ? '0 : w_win + 1'b1;
            end
        end

        // Route the winning port's command to the SRAM.
        always_comb begin
            w_sel_off   = '0;
            w_sel_we    = 1'b0;
            w_sel_be    = '0;
            w_sel_wdata = '0;
            for (int p = 0; p < N_PORTS; p++) begin
                if (w_win == PW'(p)) begin
                    w_sel_off   = w_off[p];
                    w_sel_we    = we_i[p];
                    w_sel_be    = be_i[BE_W*p +: BE_W];
                    w_sel_wdata = wdata_i[WORD_W*p +: WORD_W];
                end
            end
        end

        assign w_bgnt_all[b*N_PORTS +: N_PORTS] =
            w_hit ? (N_PORTS'(1) << w_win) : '0;

        ram_bank #(
            .BANK_WORDS (BANK_WORDS),
            .AW         (OFFW)
        ) u_ram_bank (
            .clk     (clk_i),
            .i_en    (w_hit),
            .i_we    (w_sel_we),
            .i_be    (w_sel_be),
            .i_addr  (w_sel_off),
            .i_wdata (w_sel_wdata),
            .o_rdata (w_rdata)
        );

        assign w_bank_rdata[b] = w_rdata;
    end

    // Port grant: immediate for out-of-range, otherwise from its bank arbiter.
    always_comb begin
        w_gnt = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_gnt[p] = req_i[p] & w_oor[p] & ~rst_i;
            for (int b = 0; b < N_BANKS; b++) begin
                w_gnt[p] = w_gnt[p] | w_bgnt_all[b*N_PORTS + p];
            end
        end
    end

    assign gnt_o = w_gnt;

    // First response stage: remember what was granted and where it went.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_s1[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_s1[p].valid <= w_gnt[p];
                r_s1[p].err   <= w_oor[p];
                r_s1[p].we    <= we_i[p];
                r_s1[p].bank  <= w_bank[p];
            end
        end
    end

    // Response formation: only successful reads carry data, all else is zero.
    always_comb begin
        w_rv      = '0;
        w_re      = '0;
        w_rd_flat = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_rv[p] = r_s1[p].valid;
            w_re[p] = r_s1[p].valid & r_s1[p].err;
            if (r_s1[p].valid && !r_s1[p].err && !r_s1[p].we) begin
                for (int b = 0; b < N_BANKS; b++) begin
                    if (r_s1[p].bank == BANK_IDX_W'(b)) begin
                        w_rd_flat[WORD_W*p +: WORD_W] = w_bank_rdata[b];
                    end
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_outreg
        logic [N_PORTS-1:0]        r_s2_valid;
        logic [N_PORTS-1:0]        r_s2_err;
        logic [N_PORTS*WORD_W-1:0] r_s2_rdata;

        // Optional second stage for timing closure on the read data path.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_s2_valid <= '0;
                r_s2_err   <= '0;
                r_s2_rdata <= '0;
            end else begin
                r_s2_valid <= w_rv;
                r_s2_err   <= w_re;
                r_s2_rdata <= w_rd_flat;
            end
        end

        assign rvalid_o = r_s2_valid;
        assign err_o    = r_s2_err;
        assign rdata_o  = r_s2_rdata;
    end else begin : g_noreg
        assign rvalid_o = w_rv;
        assign err_o    = w_re;
        assign rdata_o  = w_rd_flat;
    end

endmodule : banked_data_ram
`default_nettype wire

// File: tb/tb_banked_data_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_data_ram
// Description : Self-checking bench for banked_data_ram. Two instances share
//               stimulus: one without and one with the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_data_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [63:0] wdata;

    logic [1:0]  gnt0, rvalid0, err0;
    logic [63:0] rdata0;
    logic [1:0]  gnt1, rvalid1, err1;
    logic [63:0] rdata1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    banked_data_ram #(.N_PORTS(2), .N_BANKS(4), .BANK_WORDS(4096), .OUT_REG(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt0), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid0),
        .rdata_o(rdata0), .err_o(err0));

    banked_data_ram #(.N_PORTS(2), .N_BANKS(4), .BANK_WORDS(4096), .OUT_REG(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic [31:0] a,
                         input logic w, input logic [3:0] b, input logic [31:0] d);
        req[p]          = r;
        addr[32*p +: 32] = a;
        we[p]           = w;
        be[4*p +: 4]    = b;
        wdata[32*p +: 32] = d;
    endtask

    task automatic idle();
        req = '0; addr = '0; we = '0; be = '0; wdata = '0;
    endtask

    // Directed single-port vectors for OUT_REG=0 / OUT_REG=1 instances.
    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [3:0]  b;
        logic [31:0] d;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    // Reference model state for the random phase.
    int          mptr [4];
    logic [31:0] mmem [int];
    logic        ev   [2][2][4];
    logic        ee   [2][2][4];
    logic [31:0] ed   [2][2][4];
    logic        pend [2];
    logic [31:0] pool [8];
    int          cyc;
    int          resp_cnt [2];

    initial begin
        logic [1:0]  expg, prevg, g;
        logic        m_req [2];
        logic [31:0] m_a   [2];
        logic        m_w   [2];
        logic [3:0]  m_b   [2];
        logic [31:0] m_d   [2];
        logic        m_oor [2];
        logic [31:0] m_rd  [2];
        int          slot, p, sel;
        logic        found;
        logic [31:0] word;

        vt[0]  = '{32'h0000_4008, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[1]  = '{32'h0000_4008, 1'b0, 4'hF, 32'hBAD0BAD0, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{32'h0000_0100, 1'b1, 4'hF, 32'h11223344, 1'b0, 32'h0};
        vt[3]  = '{32'h0000_0100, 1'b1, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0};
        vt[4]  = '{32'h0000_0100, 1'b0, 4'h0, 32'hBAD0BAD0, 1'b0, 32'h11BB33DD};
        vt[5]  = '{32'h0000_0100, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[6]  = '{32'h0000_0102, 1'b0, 4'hF, 32'hBAD0BAD0, 1'b0, 32'h11BB33DD};
        vt[7]  = '{32'h0000_0004, 1'b1, 4'hF, 32'h55AA55AA, 1'b0, 32'h0};
        vt[8]  = '{32'h0001_0004, 1'b1, 4'hF, 32'h12345678, 1'b1, 32'h0};
        vt[9]  = '{32'h0000_0004, 1'b0, 4'hF, 32'hBAD0BAD0, 1'b0, 32'h55AA55AA};
        vt[10] = '{32'h0001_0000, 1'b0, 4'hF, 32'hBAD0BAD0, 1'b1, 32'h0};
        vt[11] = '{32'h0000_C000, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
        vt[12] = '{32'h0000_C003, 1'b0, 4'hF, 32'hBAD0BAD0, 1'b0, 32'hCAFEF00D};
        vt[13] = '{32'hFFFF_FFFC, 1'b0, 4'hF, 32'hBAD0BAD0, 1'b1, 32'h0};
        vt[14] = '{32'h0000_8000, 1'b1, 4'hF, 32'h00000000, 1'b0, 32'h0};
        vt[15] = '{32'h0000_8000, 1'b1, 4'h8, 32'hA5FFFFFF, 1'b0, 32'h0};
        vt[16] = '{32'h0000_8000, 1'b0, 4'hF, 32'hBAD0BAD0, 1'b0, 32'hA5000000};

        pool = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0100, 32'h0000_4000,
                 32'h0000_4008, 32'h0000_8000, 32'h0000_C000, 32'h0000_C004};

        // ---------------- reset state ----------------
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        drive(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
        #1;
        chk("rst_gnt_or0", gnt0, 2'b00);
        chk("rst_gnt_or1", gnt1, 2'b00);
        chk("rst_rvalid", {rvalid1, rvalid0}, 4'b0);
        chk("rst_err", {err1, err0}, 4'b0);
        chk("rst_rdata0", rdata0, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // ---------------- table: single port, back-to-back ----------------
        for (int i = 0; i < NV + 2; i++) begin
            if (i >= 1 && i - 1 < NV) begin
                chk("tbl_rvalid_or0", rvalid0, 2'b01);
                chk("tbl_err_or0", err0, {1'b0, vt[i-1].exp_err});
                chk("tbl_rdata_or0", rdata0, {32'h0, vt[i-1].exp_rdata});
            end
            if (i >= 2) begin
                chk("tbl_rvalid_or1", rvalid1, 2'b01);
                chk("tbl_err_or1", err1, {1'b0, vt[i-2].exp_err});
                chk("tbl_rdata_or1", rdata1, {32'h0, vt[i-2].exp_rdata});
            end
            if (i < NV) begin
                drive(0, 1'b1, vt[i].a, vt[i].w, vt[i].b, vt[i].d);
                #1;
                chk("tbl_gnt", gnt0, 2'b01);
            end else begin
                idle();
            end
            @(negedge clk);
        end
        chk("idle_rvalid", {rvalid1, rvalid0}, 4'b0);
        chk("idle_rdata", {rdata1, rdata0}, 128'h0);

        // ---------------- contention in bank 0 ----------------
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0A0A0A0A);
        #1 chk("pre_gnt_a", gnt0, 2'b10);
        @(negedge clk);
        drive(1, 1'b1, 32'h4, 1'b1, 4'hF, 32'h0B0B0B0B);
        #1 chk("pre_gnt_b", gnt0, 2'b10);
        @(negedge clk);
        idle();
        @(negedge clk);
        expg = 2'b01;
        prevg = 2'b00;
        resp_cnt[0] = 0;
        resp_cnt[1] = 0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                chk("cont_rvalid", rvalid0, prevg);
                chk("cont_rdata", rdata0, prevg[0] ? 64'h0000_0000_0A0A_0A0A
                                                  : 64'h0B0B_0B0B_0000_0000);
                resp_cnt[0] += int'(rvalid0[0]);
                resp_cnt[1] += int'(rvalid0[1]);
            end
            if (k < 4) begin
                drive(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
                drive(1, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
                #1 chk("cont_gnt", gnt0, expg);
                prevg = expg;
                expg  = ~expg;
            end else begin
                idle();
            end
            @(negedge clk);
        end
        chk("cont_cnt_p0", resp_cnt[0], 2);
        chk("cont_cnt_p1", resp_cnt[1], 2);

        // ---------------- parallel: bank 0 read + bank 3 write ----------------
        drive(0, 1'b1, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 32'h0000_C010, 1'b1, 4'hF, 32'h7777_1111);
        #1 chk("par_gnt", gnt0, 2'b11);
        @(negedge clk);
        idle();
        chk("par_rvalid", rvalid0, 2'b11);
        chk("par_err", err0, 2'b00);
        chk("par_rdata", rdata0, 64'h0000_0000_0A0A_0A0A);
        @(negedge clk);

        // ---------------- OUT_REG=1 with reset after grant ----------------
        drive(0, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
        #1 chk("rr_gnt_pre", gnt1, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rr_gnt_in_rst", {gnt1, gnt0}, 4'b0);
        chk("rr_or0_resp", rvalid0, 2'b01);
        chk("rr_or1_early", rvalid1, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        chk("rr_or1_dropped", rvalid1, 2'b00);
        chk("rr_or0_after", rvalid0, 2'b00);
        drive(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h0);
        drive(1, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
        #1;
        chk("rr_ptr_or0", gnt0, 2'b01);
        chk("rr_ptr_or1", gnt1, 2'b01);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        #1 chk("rr_second", gnt1, 2'b10);
        chk("rr_or1_lat1", rvalid1, 2'b00);
        @(negedge clk);
        idle();
        chk("rr_or1_lat2", rvalid1, 2'b01);
        chk("rr_or1_data", rdata1, 64'h0000_0000_0A0A_0A0A);
        @(negedge clk);
        chk("rr_or1_p1", rvalid1, 2'b10);
        chk("rr_or1_p1_data", rdata1, 64'h0B0B_0B0B_0000_0000);

        // ---------------- random traffic vs reference model ----------------
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 4; b++) mptr[b] = 0;
        for (int d = 0; d < 2; d++)
            for (int q = 0; q < 2; q++)
                for (int s = 0; s < 4; s++) begin
                    ev[d][q][s] = 1'b0; ee[d][q][s] = 1'b0; ed[d][q][s] = '0;
                end
        mmem.delete();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        cyc = 0;
        for (int c = 0; c < 600; c++) begin
            slot = cyc % 4;
            for (int d = 0; d < 2; d++) begin
                for (int q = 0; q < 2; q++) begin
                    chk("rnd_rvalid", d ? rvalid1[q] : rvalid0[q], ev[d][q][slot]);
                    chk("rnd_err", d ? err1[q] : err0[q], ee[d][q][slot]);
                    chk("rnd_rdata", d ? rdata1[32*q +: 32] : rdata0[32*q +: 32],
                        ev[d][q][slot] ? ed[d][q][slot] : 32'h0);
                    ev[d][q][slot] = 1'b0;
                    ee[d][q][slot] = 1'b0;
                    ed[d][q][slot] = '0;
                end
            end
            for (int q = 0; q < 2; q++) begin
                if (c < 8) begin
                    m_req[q] = (q == 0);
                    m_a[q] = pool[c]; m_w[q] = 1'b1; m_b[q] = 4'hF; m_d[q] = $urandom;
                end else if (!pend[q]) begin
                    m_req[q] = ($urandom_range(0, 3) != 0);
                    sel = $urandom_range(0, 9);
                    if (sel < 8)       m_a[q] = pool[sel] | 32'($urandom_range(0, 3));
                    else if (sel == 8) m_a[q] = 32'h0001_0000 | ($urandom & 32'h0000_FFFF);
                    else               m_a[q] = 32'h8000_0000 | $urandom;
                    m_w[q] = $urandom_range(0, 1) != 0;
                    m_b[q] = 4'($urandom_range(0, 15));
                    m_d[q] = $urandom;
                end
                drive(q, m_req[q], m_a[q], m_w[q], m_b[q], m_d[q]);
                m_oor[q] = (m_a[q][31:16] != 16'h0);
            end
            #1;
            // Grants: out-of-range at once, then one round-robin winner per bank.
            g = 2'b00;
            for (int q = 0; q < 2; q++) if (m_req[q] && m_oor[q]) g[q] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                found = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    p = (mptr[b] + k) % 2;
                    if (!found && m_req[p] && !m_oor[p] && int'(m_a[p][15:14]) == b) begin
                        found = 1'b1;
                        g[p] = 1'b1;
                        mptr[b] = (p + 1) % 2;
                    end
                end
            end
            chk("rnd_gnt_or0", gnt0, g);
            chk("rnd_gnt_or1", gnt1, g);
            for (int q = 0; q < 2; q++) begin
                m_rd[q] = 32'h0;
                if (g[q] && !m_w[q] && !m_oor[q]) m_rd[q] = mmem[int'(m_a[q][15:2])];
            end
            for (int q = 0; q < 2; q++) begin
                if (g[q] && m_w[q] && !m_oor[q]) begin
                    word = mmem.exists(int'(m_a[q][15:2])) ? mmem[int'(m_a[q][15:2])] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (m_b[q][i]) word[8*i +: 8] = m_d[q][8*i +: 8];
                    mmem[int'(m_a[q][15:2])] = word;
                end
                if (g[q]) begin
                    for (int d = 0; d < 2; d++) begin
                        ev[d][q][(cyc + 1 + d) % 4] = 1'b1;
                        ee[d][q][(cyc + 1 + d) % 4] = m_oor[q];
                        ed[d][q][(cyc + 1 + d) % 4] = m_rd[q];
                    end
                end
                pend[q] = m_req[q] && !g[q];
            end
            cyc++;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_banked_data_ram
`default_nettype wire

// File: doc/banked_data_ram.md
Name: banked_data_ram

Overview:
- Multi-port, multi-bank on-chip data memory for the RISC-V subsystem. Sits behind the core data port and one or more secondary masters, for example the PASTA accelerator DMA.
- Word address is split into bank index and in-bank offset. Each bank is a single-port SRAM.
- Per-bank round-robin arbitration resolves port conflicts. Non-conflicting ports are served in parallel.
- Adds out-of-range error signalling and an optional output register stage.

Parameters:
- N_PORTS, 2, number of requesting bus ports (1..4).
- N_BANKS, 4, number of SRAM banks, power of two (1..8).
- BANK_WORDS, 4096, 32-bit words per bank, power of two.
- OUT_REG, 0, 0 = response 1 cycle after grant; 1 = extra output register, response 2 cycles after grant.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  N_PORTS  per-port request.
- gnt_o  out  N_PORTS  per-port grant, combinational from req_i/addr_i and arbitration state.
- addr_i  in  N_PORTS*32  per-port byte address (port p at [32p+:32]).
- we_i  in  N_PORTS  write enable.
- be_i  in  N_PORTS*4  byte enables.
- wdata_i  in  N_PORTS*32  write data.
- rvalid_o  out  N_PORTS  response valid.
- rdata_o  out  N_PORTS*32  read data.
- err_o  out  N_PORTS  error, qualified by rvalid_o.

Behaviour:
- Decode per port:
  - offset = addr[2 +: OFFW], where OFFW = log2(BANK_WORDS).
  - bank = addr[2+OFFW +: BW], where BW = log2(N_BANKS), 0 when N_BANKS = 1.
  - addr[1:0] is ignored.
  - Bits above 2+OFFW+BW nonzero → out-of-range.
- Out-of-range request:
  - Granted immediately, no bank access.
  - Response at normal latency with err_o=1, rdata_o=0.
- Arbitration, per bank, combinational:
  - Candidates are in-range requesting ports targeting that bank.
  - Winner is the first candidate at or after rr_ptr[bank], wrapping modulo N_PORTS.
  - Winner gets gnt_o=1. Losers get gnt_o=0 and must hold req/addr/we/be/wdata stable until granted.
- Pointer update:
  - On any grant in bank b, rr_ptr[b] <= winner+1 mod N_PORTS, registered.
  - Bank with no candidates keeps its pointer.
- Bank access:
  - Granted write stores bytes where be=1; bytes with be=0 are unchanged.
  - Granted read returns the full word.
  - Write with be=0000 is legal: no state change, normal response.
- Response pipeline, per port, from the grant cycle:
  - Stage 1 (registered): valid, err, we, bank index.
  - OUT_REG=0: rvalid_o=1 in cycle T+1.
  - OUT_REG=1: stage 2 registers rdata/err; rvalid_o=1 in cycle T+2.
  - Reads: rdata_o = bank word, muxed by the registered bank index.
  - Writes: rdata_o=0, err_o=0, rvalid_o=1.
  - rdata_o=0 whenever rvalid_o=0.
- Throughput: one grant per port per cycle. Back-to-back grants give back-to-back responses, in order per port.
- Ordering:
  - Read granted in the cycle after a write to the same word (any port) returns the new data.
  - Same-cycle same-bank accesses are serialised by arbitration, so write/write races cannot occur.
- Reset, synchronous:
  - Next edge with rst_i=1 clears all rr_ptr to 0.
  - Clears all pipeline valids. rvalid_o, err_o, rdata_o are 0 from that edge.
  - gnt_o is forced 0 while rst_i=1.
  - In-flight responses are dropped. SRAM contents are undefined after reset (not cleared).

Decomposition:
- Shared package banked_ram_pkg: word/byte-enable widths, localparam helpers for OFFW/BW, a response-stage struct typedef (valid, err, we, bank).
- Sub-module ram_bank: single-port byte-write SRAM, 1-cycle registered read, BANK_WORDS x 32. It is the swap point for a hard macro wrapper.
- Arbiter stays inline in a generate-per-bank loop.

Test Plan:
- Single port, OUT_REG=0: write 0xDEADBEEF, be=1111, to 0x0000_4008 (bank 1, offset 2), then read it. Required: gnt same cycle; rvalid one cycle later; read data 0xDEADBEEF, err=0.
- Byte enables: word preset 0x11223344, write 0xAABBCCDD with be=0101, read back. Required: 0x11BB33DD.
- Contention: ports 0 and 1 both read bank 0 for 4 consecutive cycles with req held. Required grants alternate 0,1,0,1 starting with port 0 after reset. Each port gets 2 responses, each one cycle after its grant.
- Parallel access: port 0 reads bank 0 while port 1 writes bank 3 in the same cycle. Required: both granted, both rvalid next cycle.
- Error case: read of 0x0001_0000 with default params. Required: immediate gnt; rvalid=1, err=1, rdata=0 one cycle later; no bank touched.
- OUT_REG=1, with reset: OUT_REG=1 gives 2-cycle latency. Assert rst_i in the cycle after a grant. Required: no rvalid for that access, rr_ptr back to 0 (port 0 wins the next contention).
